// File: rtl/mips_instr_encoder_loader.sv
// Purpose: encodes symbolic MIPS instruction descriptors into 32-bit words and
//          writes them one after another into instruction memory from BASE_ADDR.
// Latency: imem_we asserts the cycle after the accepting edge; throughput is one word per 2 cycles.
// Backpressure: in_ready is low during WRITE, in FULL and whenever clear is high.
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   clear                 synchronous restart (index/word_count to 0, leaves FULL)
//   in_valid/in_ready     descriptor handshake; mnem/rs/rt/rd/shamt/imm16/target26 carry the descriptor
//   imem_we/addr/wdata    single-cycle IMEM write port
//   word_count, full      progress status
//   err_illegal           one-cycle pulse after an illegal mnemonic is consumed
module mips_instr_encoder_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       mnem,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [4:0]       rd,
  input  logic [4:0]       shamt,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic [CNT_W-1:0] word_count,
  output logic             full,
  output logic             err_illegal
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] index;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic [5:0]  funct;
  logic [5:0]  opcode;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [4:0]  f_sh;

  // Descriptor encoder: mnem 0..14 R-type, 15 illegal, 16..29 I-type, 30..31 J-type.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    funct     = 6'h00;
    opcode    = 6'h00;
    f_rs      = rs;
    f_rt      = rt;
    f_rd      = rd;
    f_sh      = 5'd0;
    if (mnem < 5'd15) begin
      case (mnem)
        5'd0:    funct = 6'h20;
        5'd1:    funct = 6'h21;
        5'd2:    funct = 6'h22;
        5'd3:    funct = 6'h23;
        5'd4:    funct = 6'h24;
        5'd5:    funct = 6'h25;
        5'd6:    funct = 6'h26;
        5'd7:    funct = 6'h27;
        5'd8:    funct = 6'h2A;
        5'd9:    funct = 6'h2B;
        5'd10:   funct = 6'h00;
        5'd11:   funct = 6'h02;
        5'd12:   funct = 6'h03;
        5'd13:   funct = 6'h08;
        default: funct = 6'h09;
      endcase
      // Shifts take their operand from rt and amount from shamt; rs is unused.
      if (mnem >= 5'd10 && mnem <= 5'd12) begin
        f_rs = 5'd0;
        f_sh = shamt;
      end
      if (mnem == 5'd13) begin
        f_rt = 5'd0;
        f_rd = 5'd0;
      end
      if (mnem == 5'd14) begin
        f_rt = 5'd0;
      end
      enc_word = {6'h00, f_rs, f_rt, f_rd, f_sh, funct};
    end else if (mnem == 5'd15) begin
      enc_legal = 1'b0;
    end else if (mnem < 5'd30) begin
      case (mnem)
        5'd16:   opcode = 6'h08;
        5'd17:   opcode = 6'h09;
        5'd18:   opcode = 6'h0A;
        5'd19:   opcode = 6'h0B;
        5'd20:   opcode = 6'h0C;
        5'd21:   opcode = 6'h0D;
        5'd22:   opcode = 6'h0E;
        5'd23:   opcode = 6'h0F;
        5'd24:   opcode = 6'h23;
        5'd25:   opcode = 6'h2B;
        5'd26:   opcode = 6'h20;
        5'd27:   opcode = 6'h28;
        5'd28:   opcode = 6'h04;
        default: opcode = 6'h05;
      endcase
      if (mnem == 5'd23) begin
        f_rs = 5'd0;
      end
      enc_word = {opcode, f_rs, rt, imm16};
    end else begin
      enc_word = {(mnem == 5'd30) ? 6'h02 : 6'h03, target26};
    end
  end

  // clear must suppress both the handshake and any in-flight write in its own cycle.
  assign in_ready = (state == S_IDLE) && !clear;
  assign imem_we  = (state == S_WRITE) && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      index       <= '0;
      word_count  <= '0;
      imem_wdata  <= 32'h0;
      imem_addr   <= BASE_ADDR;
      full        <= 1'b0;
      err_illegal <= 1'b0;
    end else if (clear) begin
      state       <= S_IDLE;
      index       <= '0;
      word_count  <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (enc_legal) begin
              imem_wdata <= enc_word;
              // Address is latched here so it holds steady after index advances.
              imem_addr  <= BASE_ADDR + {{(30 - IDX_W){1'b0}}, index, 2'b00};
              state      <= S_WRITE;
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          index      <= index + 1'b1;
          word_count <= word_count + 1'b1;
          if (word_count == CNT_W'(DEPTH - 1)) begin
            state <= S_FULL;
            full  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FULL: begin
          state <= S_FULL;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mips_instr_encoder_loader.md
Name: mips_instr_encoder_loader

Overview:
Inverse of the control-unit decode path. It accepts symbolic instruction descriptors (mnemonic code plus operand fields) over a valid/ready handshake. Each descriptor is encoded into a 32-bit MIPS instruction word and written sequentially into instruction memory. It is used by the boot/test harness to populate IMEM before the single-cycle core is released.

Parameters:
DEPTH, 256, number of instruction words the loader may write (power of two, >=2)
BASE_ADDR, 32'h0000_0000, byte address of the first word written
CNT_W, $clog2(DEPTH)+1, width of the word counter

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous restart: index back to 0, leave FULL
in_valid  input  1  descriptor valid
in_ready  output  1  loader can accept a descriptor
mnem  input  5  mnemonic code (table in Behaviour)
rs  input  5  source register field
rt  input  5  target register field
rd  input  5  destination register field
shamt  input  5  shift amount
imm16  input  16  immediate / branch offset
target26  input  26  jump target (word index)
imem_we  output  1  IMEM write strobe
imem_addr  output  32  IMEM byte address
imem_wdata  output  32  encoded instruction
word_count  output  CNT_W  words written since reset/clear
full  output  1  DEPTH words written
err_illegal  output  1  one-cycle pulse: illegal mnemonic consumed

Behaviour:
- Reset (rst_n=0, async): state IDLE, index 0, word_count 0, imem_wdata 0, imem_addr BASE_ADDR, imem_we 0, full 0, err_illegal 0.
- States are IDLE, WRITE and FULL.
- in_ready = (state==IDLE).
- IDLE, on in_valid&in_ready with legal mnem:
  - Register the encoded word into imem_wdata.
  - Move to WRITE.
- IDLE, on in_valid&in_ready with illegal mnem (15):
  - Descriptor is consumed.
  - err_illegal=1 the next cycle.
  - No write occurs; state stays IDLE.
- WRITE:
  - imem_we=1 for exactly one cycle, with imem_addr = BASE_ADDR + 4*index.
  - Next edge: index++ and word_count++.
  - If word_count becomes DEPTH, go to FULL; otherwise go to IDLE.
  - Throughput is one word per 2 cycles. Latency from handshake edge to imem_we is 1 cycle.
- FULL: full=1, in_ready=0, descriptors are held off. Leave FULL only by clear or reset.
- clear=1 takes priority in any state:
  - Next state IDLE; index and word_count go to 0; full goes to 0.
  - imem_we is forced 0 in that cycle, so an in-flight write is dropped.
  - A handshake in the same cycle is ignored; in_ready reads 0 while clear=1.
- Encoding for R-type (word = {6'h00, rs, rt, rd, shamt, funct}), listed as mnem=funct:
  - 0 ADD=0x20, 1 ADDU=0x21, 2 SUB=0x22, 3 SUBU=0x23
  - 4 AND=0x24, 5 OR=0x25, 6 XOR=0x26, 7 NOR=0x27
  - 8 SLT=0x2A, 9 SLTU=0x2B
  - 10 SLL=0x00, 11 SRL=0x02, 12 SRA=0x03
  - 13 JR=0x08, 14 JALR=0x09
- R-type field forcing:
  - Shifts: rs forced to 0.
  - Non-shifts: shamt forced to 0.
  - JR: rt, rd and shamt forced to 0.
  - JALR: rt and shamt forced to 0.
- Encoding for I-type (word = {op, rs, rt, imm16}), listed as mnem=op:
  - 16 ADDI=0x08, 17 ADDIU=0x09, 18 SLTI=0x0A, 19 SLTIU=0x0B
  - 20 ANDI=0x0C, 21 ORI=0x0D, 22 XORI=0x0E, 23 LUI=0x0F
  - 24 LW=0x23, 25 SW=0x2B, 26 LB=0x20, 27 SB=0x28
  - 28 BEQ=0x04, 29 BNE=0x05
  - LUI: rs forced to 0.
  - imm16 is passed through unmodified; sign is the caller's concern.
- Encoding for J-type (word = {op, target26}): 30 J=0x02, 31 JAL=0x03.
- Mnemonic 15 is illegal.
- Unused input fields are ignored. Inputs are sampled only on the accepting edge.
- imem_addr and imem_wdata hold their last values outside WRITE.

Test Plan:
- Reset then ADD rs=1 rt=2 rd=3 -> one cycle later imem_we=1, addr=0x0, wdata=0x00221820; word_count=1; in_ready low only during WRITE.
- Sequence ADDI rs=0 rt=8 imm=0xFFFF, then LW rs=29 rt=9 imm=4, then J target=0x0100000 -> writes 0x2008FFFF@0x0, 0x8FA90004@0x4, 0x08100000@0x8.
- SLL with rs=7 rd=4 rt=5 shamt=2, and JR rs=31 with junk rt/rd -> 0x00052080, 0x03E00008 (forced-zero fields verified).
- mnem=15 presented -> handshake completes, err_illegal pulses 1 cycle, imem_we stays 0, word_count unchanged.
- DEPTH=4: stream 6 descriptors -> 4 writes at 0x0..0xC, full=1, in_ready=0, 5th held; clear -> full=0, next write at 0x0.
- Assert clear during WRITE -> imem_we=0 that cycle, word_count=0; async rst_n low mid-WRITE -> all outputs to reset values immediately.
